// File: rtl/control_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module : control_sequencer                                                 |
// | Micro-step sequencer and control-word decoder for the 8-bit bus CPU.      |
// | Optional: CTRL_COND_JUMP_EN enables JC/JZ; otherwise opcodes 7/8 are NOP.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module control_sequencer #(
  parameter int EARLY_END = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       pc_inc,
  output logic       pc_out,
  output logic       pc_jump,
  output logic       mar_in,
  output logic       ram_out,
  output logic       ram_in,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       flags_in,
  output logic       out_in,
  output logic       hlt,
  output logic [2:0] step
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_e;

  typedef struct packed {
    logic pc_inc;
    logic pc_out;
    logic pc_jump;
    logic mar_in;
    logic ram_out;
    logic ram_in;
    logic ir_in;
    logic ir_out;
    logic a_in;
    logic a_out;
    logic b_in;
    logic alu_out;
    logic alu_sub;
    logic flags_in;
    logic out_in;
    logic hlt;
  } ctrl_t;

  localparam logic [3:0] c_OP_LDA = 4'h1;
  localparam logic [3:0] c_OP_ADD = 4'h2;
  localparam logic [3:0] c_OP_SUB = 4'h3;
  localparam logic [3:0] c_OP_STA = 4'h4;
  localparam logic [3:0] c_OP_LDI = 4'h5;
  localparam logic [3:0] c_OP_JMP = 4'h6;
  localparam logic [3:0] c_OP_JC  = 4'h7;
  localparam logic [3:0] c_OP_JZ  = 4'h8;
  localparam logic [3:0] c_OP_OUT = 4'hE;
  localparam logic [3:0] c_OP_HLT = 4'hF;

  // take: a conditional jump's condition holds (always 0 without the feature)
  function automatic ctrl_t decode(input step_e s, input logic [3:0] op, input logic take);
    ctrl_t w;
    w = '0;
    case (s)
      T0: begin
        w.pc_out = 1'b1;
        w.mar_in = 1'b1;
      end
      T1: begin
        w.ram_out = 1'b1;
        w.ir_in   = 1'b1;
        w.pc_inc  = 1'b1;
      end
      T2: begin
        case (op)
          c_OP_LDA, c_OP_ADD, c_OP_SUB, c_OP_STA: begin
            w.ir_out = 1'b1;
            w.mar_in = 1'b1;
          end
          c_OP_LDI: begin
            w.ir_out = 1'b1;
            w.a_in   = 1'b1;
          end
          c_OP_JMP: begin
            w.ir_out  = 1'b1;
            w.pc_jump = 1'b1;
          end
          c_OP_JC, c_OP_JZ: begin
            w.ir_out  = take;
            w.pc_jump = take;
          end
          c_OP_OUT: begin
            w.a_out  = 1'b1;
            w.out_in = 1'b1;
          end
          c_OP_HLT: w.hlt = 1'b1;
          default: ;
        endcase
      end
      T3: begin
        case (op)
          c_OP_LDA: begin
            w.ram_out = 1'b1;
            w.a_in    = 1'b1;
          end
          c_OP_ADD, c_OP_SUB: begin
            w.ram_out = 1'b1;
            w.b_in    = 1'b1;
          end
          c_OP_STA: begin
            w.a_out  = 1'b1;
            w.ram_in = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        if (op == c_OP_ADD || op == c_OP_SUB) begin
          w.alu_out  = 1'b1;
          w.a_in     = 1'b1;
          w.flags_in = 1'b1;
          w.alu_sub  = (op == c_OP_SUB);
        end
      end
      default: ;
    endcase
    return w;
  endfunction

  step_e step_q, step_d, w_succ;
  logic  halted_q, halted_d;
  ctrl_t w_cur, w_nxt, w_ctrl;
  logic  w_take;

`ifdef CTRL_COND_JUMP_EN
  assign w_take = ((opcode == c_OP_JC) && flag_c) || ((opcode == c_OP_JZ) && flag_z);
`else
  logic w_unused_flags;
  assign w_take         = 1'b0;
  assign w_unused_flags = flag_c | flag_z;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    w_succ   = T0;
    case (step_q)
      T0:      w_succ = T1;
      T1:      w_succ = T2;
      T2:      w_succ = T3;
      T3:      w_succ = T4;
      default: w_succ = T0;
    endcase
    w_cur = decode(step_q, opcode, w_take);
    w_nxt = decode(w_succ, opcode, w_take);

    // opcode is only valid from T2, so T0/T1 never end early
    if (!halted_q) begin
      if (w_cur.hlt) begin
        halted_d = 1'b1;
      end else if ((step_q == T2 || step_q == T3) && (EARLY_END != 0) && (w_nxt == '0)) begin
        step_d = T0;
      end else begin
        step_d = w_succ;
      end
    end

    w_ctrl = w_cur;
    if (halted_q) begin
      w_ctrl     = '0;
      w_ctrl.hlt = 1'b1;
    end
    if (rst) begin
      w_ctrl = '0;
    end
  end

  assign pc_inc   = w_ctrl.pc_inc;
  assign pc_out   = w_ctrl.pc_out;
  assign pc_jump  = w_ctrl.pc_jump;
  assign mar_in   = w_ctrl.mar_in;
  assign ram_out  = w_ctrl.ram_out;
  assign ram_in   = w_ctrl.ram_in;
  assign ir_in    = w_ctrl.ir_in;
  assign ir_out   = w_ctrl.ir_out;
  assign a_in     = w_ctrl.a_in;
  assign a_out    = w_ctrl.a_out;
  assign b_in     = w_ctrl.b_in;
  assign alu_out  = w_ctrl.alu_out;
  assign alu_sub  = w_ctrl.alu_sub;
  assign flags_in = w_ctrl.flags_in;
  assign out_in   = w_ctrl.out_in;
  assign hlt      = w_ctrl.hlt;
  assign step     = step_q;

endmodule
`default_nettype wire
